banner_cmd_sequencer: RTL and testbench
=======================================

// Module: banner_cmd_sequencer
// PURPOSE
//  Command sequencer between the UART RX/TX FIFOs and the banner datapath (BCD shift register, 7-seg drivers).
//  Pops command bytes, collects NUM_DIGITS ASCII digits into a packed BCD word and commits it with one write pulse.
//  Issues start/pause/left/right strobes, generates the scroll-step tick and returns 'K'/'?' ack bytes on TX.
// PARAMETERS
//  NUM_DIGITS      6           digits per banner; sr_data width = 4*NUM_DIGITS
//  BASE_DIV        5_000_000   clk cycles per scroll step at speed 0; period = BASE_DIV*(speed+1)
//  TIMEOUT_CYCLES  50_000_000  idle cycles allowed between digit bytes before the entry is aborted
// PORTS
//  clk          in   1             system clock, all state on rising edge
//  reset        in   1             asynchronous, active-high; clears all state
//  rx_empty     in   1             RX FIFO empty; rx_data valid while low (first-word-fall-through)
//  rx_data      in   8             head byte of RX FIFO
//  rd_data      out  1             1-cycle pop of RX FIFO; never high while rx_empty=1
//  tx_full      in   1             TX FIFO full
//  tx_data      out  8             ack byte, valid while wr_data=1
//  wr_data      out  1             1-cycle push to TX FIFO; never high while tx_full=1
//  sr_data      out  4*NUM_DIGITS  packed BCD, first received digit in MS nibble
//  sr_write     out  1             1-cycle load strobe for shift register
//  sr_start     out  1             1-cycle start strobe
//  sr_pause     out  1             1-cycle pause strobe
//  sr_left      out  1             1-cycle direction-left strobe
//  sr_right     out  1             1-cycle direction-right strobe
//  scroll_tick  out  1             1-cycle scroll-step pulse, only while running
//  banner_write out  1             high while in DIGITS state (entry in progress)
//  running      out  1             scroll enabled flag
// BEHAVIOUR
//  Reset: state=CMD; all strobes, rd_data, wr_data, banner_write, running, scroll_tick = 0.
//   sr_data=0, tx_data=0, speed=3, digit count=0, prescaler=0, timeout counter=0.
//  Pop rule: rd_data = ~rx_empty in CMD and DIGITS only. The byte is consumed that cycle; at most 1 byte/cycle.
//  CMD state; commands are case-insensitive. Every consumed byte leads to DIGITS or ACK:
//   'w' -> DIGITS; buffer=0, count=0.
//   's' -> sr_start, running<=1, ACK('K').
//   'p' -> sr_pause, running<=0, prescaler<=0, ACK('K').
//   'l' -> sr_left, ACK('K').      'r' -> sr_right, ACK('K').
//   '+' -> speed<=max(speed-1,0), ACK('K').   '-' -> speed<=min(speed+1,7), ACK('K').
//   Any other byte -> ACK('?'); no strobe.
//   All strobes assert in the cycle after the pop (registered) and last exactly 1 cycle.
//  DIGITS state (banner_write=1):
//   Byte 0x30..0x39 -> buffer <= {buffer[4*NUM_DIGITS-5:0], byte-0x30}; count++; timeout<=0.
//   When count reaches NUM_DIGITS -> COMMIT.
//   0x1B (ESC) or any non-digit -> abort: buffer discarded, sr_data unchanged, ACK('?').
//   timeout counter increments each cycle with no pop; at TIMEOUT_CYCLES-1 -> abort, ACK('?').
//  COMMIT: sr_data<=buffer and sr_write=1 for one cycle (sr_data valid with the strobe) -> ACK('K').
//   COMMIT entered the cycle after the last digit pop.
//   sr_data holds its value until the next COMMIT.
//  ACK: waits while tx_full=1 (no RX pops). Next cycle with tx_full=0: wr_data=1, tx_data=ack byte -> CMD.
//  Scroll tick:
//   prescaler counts only while running=1.
//   At BASE_DIV*(speed+1)-1: scroll_tick=1 for one cycle, prescaler<=0.
//   A speed change takes effect at the next wrap; if the prescaler is already >= the new period, wrap next cycle.
//   Ticks continue during DIGITS/COMMIT/ACK.
//  Reset mid-entry: the partial buffer is lost, no sr_write, no ack byte sent.
//  Arithmetic: count is $clog2(NUM_DIGITS+1) bits; speed is 3 bits; period is computed at 32-bit width.
// TESTING (NUM_DIGITS=6, BASE_DIV=4, TIMEOUT_CYCLES=20)
//  1. Bytes "w123456" -> one sr_write, sr_data=24'h123456; tx 'K'; banner_write high from 'w' until COMMIT.
//  2. "w12x" -> no sr_write, sr_data keeps old value, tx '?'; state back to CMD.
//  3. "w12" then 20 idle cycles -> abort, tx '?'.
//  4. 's' -> sr_start pulse; scroll_tick every 16 cycles (speed 3).
//     "++" -> period 8; 'p' -> ticks stop, running=0.
//  5. Send 'S' with tx_full=1 for 10 cycles -> wr_data stays low, no further pops; 'K' pushed the cycle after tx_full falls.
//  6. Assert reset mid "w123" -> all outputs reset values; next "w000000" commits 24'h000000.

Source files
------------

// File: rtl/banner_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// banner_cmd_sequencer
//
// Sits between the UART RX/TX FIFOs and the banner datapath. Pops command
// bytes from the RX FIFO and turns them into single-cycle strobes for the
// BCD shift register, collects NUM_DIGITS ASCII digits into a packed BCD word
// committed with one sr_write pulse, generates the scroll-step tick, and
// answers every consumed command with an ack byte ('K' = ok, '?' = rejected).
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   rx_empty, rx_data     RX FIFO status and head byte (first-word-fall-through)
//   rd_data               RX FIFO pop
//   tx_full               TX FIFO status
//   tx_data, wr_data      TX FIFO push byte and push strobe
//   sr_data, sr_write     packed BCD word and its load strobe
//   sr_start, sr_pause    start / pause strobes
//   sr_left, sr_right     scroll direction strobes
//   scroll_tick           one scroll step, only while running
//   banner_write          high while a digit entry is in progress
//   running               scroll enabled flag
//
// FIFO handshake: the RX side is "valid = ~rx_empty, ready = rd_data"; a byte
// is consumed in exactly the cycle where rd_data is high, and rd_data is never
// high unless rx_empty is low. The TX side is "valid = wr_data,
// ready = ~tx_full"; wr_data is only raised when tx_full is low, so every
// asserted wr_data cycle is a completed push.
// -----------------------------------------------------------------------------
module banner_cmd_sequencer #(
    parameter int NUM_DIGITS     = 6,
    parameter int BASE_DIV       = 5_000_000,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rx_empty,
    input  logic [7:0]              rx_data,
    output logic                    rd_data,
    input  logic                    tx_full,
    output logic [7:0]              tx_data,
    output logic                    wr_data,
    output logic [4*NUM_DIGITS-1:0] sr_data,
    output logic                    sr_write,
    output logic                    sr_start,
    output logic                    sr_pause,
    output logic                    sr_left,
    output logic                    sr_right,
    output logic                    scroll_tick,
    output logic                    banner_write,
    output logic                    running
);

    localparam int W  = 4 * NUM_DIGITS;
    localparam int CW = $clog2(NUM_DIGITS + 1);

    localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);
    localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   BASE       = 32'(BASE_DIV);
    localparam logic [7:0]    ACK_OK     = 8'h4B;  // 'K'
    localparam logic [7:0]    ACK_ERR    = 8'h3F;  // '?'

    typedef enum logic [1:0] {
        S_CMD,
        S_DIGITS,
        S_COMMIT,
        S_ACK
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    buffer, buffer_n;
    logic [W-1:0]    sr_data_n;
    logic [CW-1:0]   count, count_n;
    logic [31:0]     timeout, timeout_n;
    logic [7:0]      ack, ack_n;
    logic [2:0]      speed, speed_n;
    logic            running_n;
    logic            start_n, pause_n, left_n, right_n, write_n;
    logic            pre_clear;
    logic [31:0]     prescaler;
    logic [31:0]     period;
    logic [7:0]      lc;
    logic            is_digit;

    // Fold upper-case letters onto lower case so command decode is
    // case-insensitive; other bytes pass through unchanged.
    assign lc       = (rx_data >= 8'h41 && rx_data <= 8'h5A) ? (rx_data | 8'h20) : rx_data;
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        buffer_n  = buffer;
        sr_data_n = sr_data;
        count_n   = count;
        timeout_n = timeout;
        ack_n     = ack;
        speed_n   = speed;
        running_n = running;
        start_n   = 1'b0;
        pause_n   = 1'b0;
        left_n    = 1'b0;
        right_n   = 1'b0;
        write_n   = 1'b0;
        pre_clear = 1'b0;
        rd_data   = 1'b0;
        wr_data   = 1'b0;

        case (state)
            S_CMD: begin
                rd_data = ~rx_empty;
                if (!rx_empty) begin
                    state_n = S_ACK;
                    ack_n   = ACK_OK;
                    case (lc)
                        "w": begin
                            state_n   = S_DIGITS;
                            buffer_n  = '0;
                            count_n   = '0;
                            timeout_n = '0;
                        end
                        "s": begin
                            start_n   = 1'b1;
                            running_n = 1'b1;
                        end
                        "p": begin
                            pause_n   = 1'b1;
                            running_n = 1'b0;
                            pre_clear = 1'b1;
                        end
                        "l": left_n = 1'b1;
                        "r": right_n = 1'b1;
                        "+": speed_n = (speed == 3'd0) ? 3'd0 : speed - 3'd1;
                        "-": speed_n = (speed == 3'd7) ? 3'd7 : speed + 3'd1;
                        default: ack_n = ACK_ERR;
                    endcase
                end
            end

            S_DIGITS: begin
                rd_data = ~rx_empty;
                if (!rx_empty) begin
                    if (is_digit) begin
                        // For an ASCII digit, the low nibble is the BCD value.
                        buffer_n  = {buffer[W-5:0], rx_data[3:0]};
                        count_n   = count + CW'(1);
                        timeout_n = '0;
                        if (count == LAST_DIGIT) begin
                            // sr_data and sr_write become visible together
                            // in the COMMIT cycle.
                            state_n   = S_COMMIT;
                            sr_data_n = {buffer[W-5:0], rx_data[3:0]};
                            write_n   = 1'b1;
                        end
                    end else begin
                        state_n = S_ACK;
                        ack_n   = ACK_ERR;
                    end
                end else if (timeout == TO_LAST) begin
                    state_n = S_ACK;
                    ack_n   = ACK_ERR;
                end else begin
                    timeout_n = timeout + 32'd1;
                end
            end

            S_COMMIT: begin
                state_n = S_ACK;
                ack_n   = ACK_OK;
            end

            S_ACK: begin
                wr_data = ~tx_full;
                if (!tx_full) begin
                    state_n = S_CMD;
                end
            end

            default: state_n = S_CMD;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_CMD;
            buffer   <= '0;
            sr_data  <= '0;
            count    <= '0;
            timeout  <= '0;
            ack      <= 8'h00;
            speed    <= 3'd3;
            running  <= 1'b0;
            sr_start <= 1'b0;
            sr_pause <= 1'b0;
            sr_left  <= 1'b0;
            sr_right <= 1'b0;
            sr_write <= 1'b0;
        end else begin
            state    <= state_n;
            buffer   <= buffer_n;
            sr_data  <= sr_data_n;
            count    <= count_n;
            timeout  <= timeout_n;
            ack      <= ack_n;
            speed    <= speed_n;
            running  <= running_n;
            sr_start <= start_n;
            sr_pause <= pause_n;
            sr_left  <= left_n;
            sr_right <= right_n;
            sr_write <= write_n;
        end
    end

    assign tx_data      = ack;
    assign banner_write = (state == S_DIGITS);

    // -------------------------------------------------------------------------
    // Scroll prescaler. The period follows the live speed value, so a speed
    // change lands at the next wrap; '>=' makes a prescaler that is already
    // past a shortened period wrap straight away instead of running to 2^32.
    // -------------------------------------------------------------------------
    assign period      = BASE * (32'(speed) + 32'd1);
    assign scroll_tick = running && (prescaler >= period - 32'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
        end else if (pre_clear) begin
            prescaler <= '0;
        end else if (running) begin
            prescaler <= scroll_tick ? 32'd0 : prescaler + 32'd1;
        end
    end

endmodule

// File: tb/tb_banner_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_banner_cmd_sequencer
//
// Bench for banner_cmd_sequencer with NUM_DIGITS=6, BASE_DIV=4,
// TIMEOUT_CYCLES=20. An RX FIFO model feeds bytes from rx_q; a negedge
// monitor scores every TX push against exp_q and every sr_write against
// exp_sr_q, and counts strobes, pops, ticks and banner_write cycles.
// -----------------------------------------------------------------------------
module tb_banner_cmd_sequencer;

    localparam int ND = 6;
    localparam int BD = 4;
    localparam int TO = 20;

    // ---------------- clock / reset ----------------
    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            rx_empty = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            tx_full = 1'b0;
    logic            rd_data, wr_data, sr_write, sr_start, sr_pause, sr_left, sr_right;
    logic            scroll_tick, banner_write, running;
    logic [7:0]      tx_data;
    logic [4*ND-1:0] sr_data;

    always #5 clk = ~clk;

    banner_cmd_sequencer #(
        .NUM_DIGITS    (ND),
        .BASE_DIV      (BD),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .rd_data     (rd_data),
        .tx_full     (tx_full),
        .tx_data     (tx_data),
        .wr_data     (wr_data),
        .sr_data     (sr_data),
        .sr_write    (sr_write),
        .sr_start    (sr_start),
        .sr_pause    (sr_pause),
        .sr_left     (sr_left),
        .sr_right    (sr_right),
        .scroll_tick (scroll_tick),
        .banner_write(banner_write),
        .running     (running)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]      rx_q[$];
    logic [7:0]      exp_q[$];
    logic [4*ND-1:0] exp_sr_q[$];

    int   cyc = 0, n_pop = 0, n_wr = 0, n_write = 0, n_bw = 0;
    int   n_start = 0, n_pause = 0, n_left = 0, n_right = 0;
    int   n_tick = 0, last_tick = -1, tick_gap = 0;
    logic pop_pend = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- monitor (mid-cycle sampling) ----------------
    always @(negedge clk) begin
        if (!reset) begin
            cyc++;
            if (rd_data) begin
                check("rd_while_empty", 32'(rx_empty), 32'd0);
                n_pop++;
                pop_pend = 1'b1;
            end
            if (wr_data) begin
                check("wr_while_full", 32'(tx_full), 32'd0);
                n_wr++;
                check("tx_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
            end
            if (sr_write) begin
                n_write++;
                check("sr_write_expected", 32'(exp_sr_q.size() != 0), 32'd1);
                if (exp_sr_q.size() != 0) check("sr_data_commit", 32'(sr_data), 32'(exp_sr_q.pop_front()));
            end
            if (sr_start) n_start++;
            if (sr_pause) n_pause++;
            if (sr_left) n_left++;
            if (sr_right) n_right++;
            if (banner_write) n_bw++;
            if (scroll_tick) begin
                check("tick_while_stopped", 32'(running), 32'd1);
                if (last_tick >= 0) tick_gap = cyc - last_tick;
                last_tick = cyc;
                n_tick++;
            end
        end
    end

    // ---------------- RX FIFO model (first-word-fall-through) ----------------
    always @(posedge clk) begin
        #1;
        if (pop_pend && rx_q.size() != 0) void'(rx_q.pop_front());
        pop_pend = 1'b0;
        rx_empty = (rx_q.size() == 0);
        rx_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
    end

    // ---------------- driver tasks ----------------
    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) rx_q.push_back(s[i]);
    endtask

    task automatic wait_done(input int budget, input bit rand_full);
        int k = 0;
        while ((rx_q.size() != 0 || exp_q.size() != 0 || exp_sr_q.size() != 0) && k < budget) begin
            @(posedge clk);
            #1;
            tx_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            k++;
        end
        tx_full = 1'b0;
        check("done_within_budget", 32'(k < budget), 32'd1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n, input int budget);
        int t0 = n_tick;
        int k  = 0;
        while (n_tick < t0 + n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("ticks_within_budget", 32'(k < budget), 32'd1);
    endtask

    function automatic logic [31:0] out_flags();
        return {22'd0, rd_data, wr_data, sr_write, sr_start, sr_pause, sr_left,
                sr_right, scroll_tick, banner_write, running};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] cmd;
        logic [7:0] ack;
        logic [3:0] strb;   // {start, pause, left, right}
        logic       run;
    } vec_t;

    vec_t vecs[12];

    // ---------------- reference model for random phase ----------------
    int              m_speed;
    logic            m_running;
    logic [4*ND-1:0] m_sr;
    int              e_start, e_pause, e_left, e_right;

    // Applies one command byte to the model, returns its ack byte.
    function automatic logic [7:0] model_cmd(input logic [7:0] b);
        case (b)
            "s", "S": begin e_start++; m_running = 1'b1; return "K"; end
            "p", "P": begin e_pause++; m_running = 1'b0; return "K"; end
            "l", "L": begin e_left++;  return "K"; end
            "r", "R": begin e_right++; return "K"; end
            "+":      begin if (m_speed > 0) m_speed--; return "K"; end
            "-":      begin if (m_speed < 7) m_speed++; return "K"; end
            default:  return "?";
        endcase
    endfunction

    // ---------------- main test ----------------
    initial begin
        int s0, p0, l0, r0, w0, b0, t0, q0;
        logic [7:0] cmds[10];
        logic [7:0] bads[4];
        logic [7:0] b;
        logic [4*ND-1:0] val;

        vecs[0]  = '{8'h73, 8'h4B, 4'b1000, 1'b1};  // s
        vecs[1]  = '{8'h50, 8'h4B, 4'b0100, 1'b0};  // P
        vecs[2]  = '{8'h6C, 8'h4B, 4'b0010, 1'b0};  // l
        vecs[3]  = '{8'h52, 8'h4B, 4'b0001, 1'b0};  // R
        vecs[4]  = '{8'h53, 8'h4B, 4'b1000, 1'b1};  // S
        vecs[5]  = '{8'h4C, 8'h4B, 4'b0010, 1'b1};  // L
        vecs[6]  = '{8'h78, 8'h3F, 4'b0000, 1'b1};  // x
        vecs[7]  = '{8'h2B, 8'h4B, 4'b0000, 1'b1};  // +
        vecs[8]  = '{8'h2D, 8'h4B, 4'b0000, 1'b1};  // -
        vecs[9]  = '{8'h70, 8'h4B, 4'b0100, 1'b0};  // p
        vecs[10] = '{8'h1B, 8'h3F, 4'b0000, 1'b0};  // ESC in CMD
        vecs[11] = '{8'h30, 8'h3F, 4'b0000, 1'b0};  // digit in CMD

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset_flags", out_flags(), 32'd0);
        check("reset_sr_data", 32'(sr_data), 32'd0);
        check("reset_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_flags", out_flags(), 32'd0);

        // Single-byte command table
        for (int i = 0; i < 12; i++) begin
            s0 = n_start; p0 = n_pause; l0 = n_left; r0 = n_right;
            rx_q.push_back(vecs[i].cmd);
            exp_q.push_back(vecs[i].ack);
            wait_done(50, 1'b0);
            check("vec_strobes",
                  {16'd0, 4'(n_start - s0), 4'(n_pause - p0), 4'(n_left - l0), 4'(n_right - r0)},
                  {16'd0, 3'd0, vecs[i].strb[3], 3'd0, vecs[i].strb[2],
                   3'd0, vecs[i].strb[1], 3'd0, vecs[i].strb[0]});
            check("vec_running", 32'(running), 32'(vecs[i].run));
        end

        // 1. full entry
        w0 = n_write; b0 = n_bw;
        send_str("w123456");
        exp_q.push_back("K");
        exp_sr_q.push_back(24'h123456);
        wait_done(100, 1'b0);
        check("entry_sr_writes", 32'(n_write - w0), 32'd1);
        check("entry_sr_data", 32'(sr_data), 32'h123456);
        check("entry_banner_cycles", 32'(n_bw - b0), 32'd6);
        check("entry_banner_low_after", 32'(banner_write), 32'd0);

        // 2. aborted by a non-digit
        w0 = n_write; b0 = n_bw;
        send_str("w12x");
        exp_q.push_back("?");
        wait_done(100, 1'b0);
        check("abort_no_write", 32'(n_write - w0), 32'd0);
        check("abort_sr_kept", 32'(sr_data), 32'h123456);
        check("abort_banner_cycles", 32'(n_bw - b0), 32'd3);

        // 3. aborted by timeout: 2 digit cycles + 20 idle cycles in entry
        w0 = n_write; b0 = n_bw;
        send_str("w12");
        exp_q.push_back("?");
        wait_done(200, 1'b0);
        check("timeout_no_write", 32'(n_write - w0), 32'd0);
        check("timeout_banner_cycles", 32'(n_bw - b0), 32'd22);
        check("timeout_sr_kept", 32'(sr_data), 32'h123456);

        // 4. scroll ticks
        send_str("s");
        exp_q.push_back("K");
        wait_done(50, 1'b0);
        wait_ticks(3, 200);
        check("tick_gap_speed3", 32'(tick_gap), 32'd16);
        send_str("++");
        exp_q.push_back("K");
        exp_q.push_back("K");
        wait_done(50, 1'b0);
        wait_ticks(2, 200);
        check("tick_gap_speed1", 32'(tick_gap), 32'd8);
        send_str("p");
        exp_q.push_back("K");
        wait_done(50, 1'b0);
        t0 = n_tick;
        repeat (40) @(posedge clk);
        #1;
        check("no_ticks_paused", 32'(n_tick - t0), 32'd0);
        check("paused_running", 32'(running), 32'd0);

        // 5. TX back-pressure
        @(posedge clk);
        #1;
        tx_full = 1'b1;
        q0 = n_wr; p0 = n_pop;
        send_str("Sl");
        exp_q.push_back("K");
        exp_q.push_back("K");
        repeat (10) @(posedge clk);
        #1;
        check("stall_no_push", 32'(n_wr - q0), 32'd0);
        check("stall_one_pop", 32'(n_pop - p0), 32'd1);
        tx_full = 1'b0;
        @(negedge clk);
        #1;
        check("stall_push_on_release", 32'(n_wr - q0), 32'd1);
        wait_done(50, 1'b0);
        check("stall_running", 32'(running), 32'd1);

        // 6. reset mid-entry
        p0 = n_pop;
        send_str("w123");
        t0 = 0;
        while (n_pop - p0 < 4 && t0 < 50) begin
            @(negedge clk);
            t0++;
        end
        check("mid_entry_pops", 32'(n_pop - p0), 32'd4);
        @(posedge clk);
        #3;
        reset = 1'b1;
        rx_q.delete();
        exp_q.delete();
        exp_sr_q.delete();
        @(posedge clk);
        #2;
        check("midreset_flags", out_flags(), 32'd0);
        check("midreset_sr_data", 32'(sr_data), 32'd0);
        check("midreset_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        w0 = n_write; q0 = n_wr;
        repeat (10) @(posedge clk);
        #1;
        check("midreset_no_ack", 32'(n_wr - q0), 32'd0);
        check("midreset_no_write", 32'(n_write - w0), 32'd0);
        send_str("w000000");
        exp_q.push_back("K");
        exp_sr_q.push_back(24'h000000);
        wait_done(100, 1'b0);
        check("post_reset_commit", 32'(n_write - w0), 32'd1);
        send_str("s");
        exp_q.push_back("K");
        wait_done(50, 1'b0);
        wait_ticks(3, 200);
        check("tick_gap_after_reset", 32'(tick_gap), 32'd16);
        send_str("p");
        exp_q.push_back("K");
        wait_done(50, 1'b0);

        // Randomized command stream against the reference model
        cmds = '{"s", "S", "p", "P", "l", "L", "r", "R", "+", "-"};
        bads = '{8'h1B, "z", "W", "+"};
        m_speed = 3; m_running = 1'b0; m_sr = '0;
        e_start = 0; e_pause = 0; e_left = 0; e_right = 0;
        s0 = n_start; p0 = n_pause; l0 = n_left; r0 = n_right;
        for (int it = 0; it < 40; it++) begin
            int kind = $urandom_range(0, 9);
            if (kind <= 5) begin
                b = cmds[$urandom_range(0, 9)];
                rx_q.push_back(b);
                exp_q.push_back(model_cmd(b));
            end else if (kind == 6) begin
                b = 8'($urandom_range(128, 255));
                rx_q.push_back(b);
                exp_q.push_back(model_cmd(b));
            end else if (kind <= 8) begin
                val = '0;
                rx_q.push_back(($urandom_range(0, 1) == 0) ? "w" : "W");
                for (int d = 0; d < ND; d++) begin
                    int dig = $urandom_range(0, 9);
                    rx_q.push_back(8'(8'h30 + dig));
                    val = val * 16 + (4*ND)'(dig);
                end
                exp_q.push_back("K");
                exp_sr_q.push_back(val);
                m_sr = val;
            end else begin
                int k = $urandom_range(0, ND - 1);
                rx_q.push_back("w");
                for (int d = 0; d < k; d++) rx_q.push_back(8'(8'h30 + $urandom_range(0, 9)));
                rx_q.push_back(bads[$urandom_range(0, 3)]);
                exp_q.push_back("?");
            end
        end
        wait_done(5000, 1'b1);
        check("rand_start_count", 32'(n_start - s0), 32'(e_start));
        check("rand_pause_count", 32'(n_pause - p0), 32'(e_pause));
        check("rand_left_count", 32'(n_left - l0), 32'(e_left));
        check("rand_right_count", 32'(n_right - r0), 32'(e_right));
        check("rand_running", 32'(running), 32'(m_running));
        check("rand_sr_data", 32'(sr_data), 32'(m_sr));

        // Final speed from the model sets the scroll period
        send_str("s");
        exp_q.push_back("K");
        wait_done(50, 1'b0);
        wait_ticks(3, 300);
        check("rand_tick_gap", 32'(tick_gap), 32'(BD * (m_speed + 1)));
        send_str("p");
        exp_q.push_back("K");
        wait_done(50, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
